// File: rtl/taskwait_table_pkg.sv
// Shared definitions for the OmpSs taskwait tracker: header field positions,
// controller state encoding and the layout of one table entry.
package OmpSsManager;

    // Header beat layout: component count in the low bits, message type above it
    localparam int TW_TYPE_B = 32;
    localparam int TW_COMP_H = 31;
    localparam int TW_COMP_L = 0;

    // Widest field sizes any parameterisation may use; narrower choices zero/sign-extend
    localparam int TW_ACC_MAX_W    = 8;
    localparam int TW_TASKID_MAX_W = 64;

    typedef enum logic [1:0] {
        RD_HDR = 2'd0,
        RD_TID = 2'd1,
        LOOKUP = 2'd2,
        UPDATE = 2'd3
    } tw_state_t;

    typedef struct packed {
        logic                       valid;
        logic [TW_ACC_MAX_W-1:0]    acc_id;
        logic [TW_COMP_H:0]         cnt;
        logic [TW_TASKID_MAX_W-1:0] task_id;
    } tw_entry_t;

endpackage

// File: rtl/taskwait_table_wakeup_fifo.sv
// Small synchronous FIFO holding accelerator ids waiting to be woken.
// The head is visible combinationally (fall-through); a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module tw_wakeup_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices coincide
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_reg[PTR_W-1:0]];

    // Pointer bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage needs no reset: contents are only visible between the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/taskwait_table.sv
// Taskwait tracker: accumulates per-parent net child counts from WAIT and
// FINISH messages and wakes the waiting accelerator when the count hits zero.
module taskwait_table
    import OmpSsManager::*;
#(
    parameter int MAX_ACCS   = 16,
    parameter int TW_ENTRIES = 16,
    parameter int TASKID_W   = 64,
    parameter int CNT_W      = 32,
    parameter int WAKE_DEPTH = 4,
    localparam int ACC_BITS  = $clog2(MAX_ACCS),
    localparam int IDX_W     = $clog2(TW_ENTRIES),
    localparam int BUSY_W    = $clog2(TW_ENTRIES + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [63:0]         inStream_TDATA,
    input  logic                inStream_TVALID,
    input  logic [ACC_BITS-1:0] inStream_TID,
    output logic                inStream_TREADY,
    output logic [7:0]          outStream_TDATA,
    output logic                outStream_TVALID,
    input  logic                outStream_TREADY,
    output logic [ACC_BITS-1:0] outStream_TDEST,
    output logic                tw_overflow,
    output logic [BUSY_W-1:0]   tw_busy_entries
);

    tw_state_t           state_reg, state_next;
    logic                rdy_en_reg;
    logic                is_wait_reg;
    logic [CNT_W-1:0]    comp_reg;
    logic [ACC_BITS-1:0] tid_reg;
    logic [TASKID_W-1:0] id_reg;
    logic                hit_reg;
    logic                free_ok_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                tw_overflow_reg;
    tw_entry_t           tbl_reg [TW_ENTRIES];

    logic [TW_ENTRIES-1:0] match_vec;
    logic [TW_ENTRIES-1:0] free_vec;
    logic [IDX_W-1:0]      match_idx;
    logic [IDX_W-1:0]      free_idx;
    logic                  hdr_take, id_take;
    logic [CNT_W-1:0]      cur_cnt, new_cnt;
    logic [ACC_BITS-1:0]   new_acc;
    logic                  done, drop, stall, upd_go;
    tw_entry_t             tbl_wdata;
    logic                  fifo_full, fifo_empty, fifo_pop;
    logic                  unused_bits;

    // Parallel compare of the latched id against every valid entry
    for (genvar gi = 0; gi < TW_ENTRIES; gi++) begin : g_match
        assign match_vec[gi] = tbl_reg[gi].valid &&
                               (tbl_reg[gi].task_id == TW_TASKID_MAX_W'(id_reg));
        assign free_vec[gi]  = !tbl_reg[gi].valid;
    end

    // Encode the (unique) hit and the lowest-numbered free slot
    always_comb begin
        match_idx = '0;
        free_idx  = '0;
        for (int i = TW_ENTRIES - 1; i >= 0; i--) begin
            if (match_vec[i]) match_idx = IDX_W'(i);
            if (free_vec[i])  free_idx  = IDX_W'(i);
        end
    end

    // Next count, wakeup and overflow decisions, all from LOOKUP results
    always_comb begin
        cur_cnt = hit_reg ? tbl_reg[idx_reg].cnt[CNT_W-1:0] : '0;
        new_cnt = is_wait_reg ? (cur_cnt - comp_reg) : (cur_cnt + CNT_W'(1));
        new_acc = (is_wait_reg || !hit_reg) ? tid_reg
                                            : tbl_reg[idx_reg].acc_id[ACC_BITS-1:0];
        done    = (new_cnt == '0);
        drop    = !hit_reg && !free_ok_reg && !done;
        stall   = done && fifo_full && !fifo_pop;
        upd_go  = (state_reg == UPDATE) && !stall;
        tbl_wdata.valid   = !done;
        tbl_wdata.acc_id  = TW_ACC_MAX_W'(new_acc);
        tbl_wdata.cnt     = (TW_COMP_H + 1)'(signed'(new_cnt));
        tbl_wdata.task_id = TW_TASKID_MAX_W'(id_reg);
    end

    // Controller state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_reg <= RD_HDR;
        else       state_reg <= state_next;
    end

    // Next state and intake ready; ready is held off one cycle after reset
    always_comb begin
        state_next      = state_reg;
        inStream_TREADY = 1'b0;
        hdr_take        = 1'b0;
        id_take         = 1'b0;
        unique case (state_reg)
            RD_HDR: begin
                inStream_TREADY = rdy_en_reg;
                hdr_take        = rdy_en_reg && inStream_TVALID;
                if (hdr_take) state_next = RD_TID;
            end
            RD_TID: begin
                inStream_TREADY = rdy_en_reg;
                id_take         = rdy_en_reg && inStream_TVALID;
                if (id_take) state_next = LOOKUP;
            end
            LOOKUP: state_next = UPDATE;
            UPDATE: if (upd_go) state_next = RD_HDR;
            default: state_next = RD_HDR;
        endcase
    end

    // Message fields and lookup results
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            is_wait_reg <= 1'b0;
            comp_reg    <= '0;
            tid_reg     <= '0;
            id_reg      <= '0;
            hit_reg     <= 1'b0;
            free_ok_reg <= 1'b0;
            idx_reg     <= '0;
        end else begin
            if (hdr_take) begin
                is_wait_reg <= inStream_TDATA[TW_TYPE_B];
                comp_reg    <= inStream_TDATA[TW_COMP_L +: CNT_W];
                tid_reg     <= inStream_TID;
            end
            if (id_take) id_reg <= inStream_TDATA[TASKID_W-1:0];
            if (state_reg == LOOKUP) begin
                hit_reg     <= |match_vec;
                free_ok_reg <= |free_vec;
                idx_reg     <= (|match_vec) ? match_idx : free_idx;
            end
        end
    end

    // Table write, sticky overflow flag and post-reset ready enable
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < TW_ENTRIES; i++) tbl_reg[i] <= '0;
            tw_overflow_reg <= 1'b0;
            rdy_en_reg      <= 1'b0;
        end else begin
            rdy_en_reg <= 1'b1;
            if (upd_go) begin
                if (drop)                    tw_overflow_reg <= 1'b1;
                else if (hit_reg || !done)   tbl_reg[idx_reg] <= tbl_wdata;
            end
        end
    end

    // Occupancy count of valid entries
    always_comb begin
        tw_busy_entries = '0;
        for (int i = 0; i < TW_ENTRIES; i++)
            tw_busy_entries = tw_busy_entries + BUSY_W'(tbl_reg[i].valid);
    end

    // Field bits that narrower parameter choices leave unread
    always_comb begin
        unused_bits = ^inStream_TDATA;
        for (int i = 0; i < TW_ENTRIES; i++)
            unused_bits = unused_bits ^ (^{tbl_reg[i].acc_id, tbl_reg[i].cnt});
    end

    assign fifo_pop         = outStream_TVALID && outStream_TREADY;
    assign outStream_TVALID = !fifo_empty;
    assign outStream_TDATA  = 8'd1;
    assign tw_overflow      = tw_overflow_reg;

    tw_wakeup_fifo #(
        .WIDTH (ACC_BITS),
        .DEPTH (WAKE_DEPTH)
    ) u_wake_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      ((state_reg == UPDATE) && done),
        .push_data (new_acc),
        .pop       (fifo_pop),
        .head      (outStream_TDEST),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_taskwait_table.sv
// Directed bench for taskwait_table: scripted WAIT/FINISH sequences with
// hand-computed wakeups, occupancy and overflow expectations.
module tb_taskwait_table;

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] inStream_TDATA;
    logic        inStream_TVALID;
    logic [3:0]  inStream_TID;
    logic        inStream_TREADY;
    logic [7:0]  outStream_TDATA;
    logic        outStream_TVALID;
    logic        outStream_TREADY;
    logic [3:0]  outStream_TDEST;
    logic        tw_overflow;
    logic [4:0]  tw_busy_entries;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    taskwait_table dut (
        .clk              (clk),
        .rstn             (rstn),
        .inStream_TDATA   (inStream_TDATA),
        .inStream_TVALID  (inStream_TVALID),
        .inStream_TID     (inStream_TID),
        .inStream_TREADY  (inStream_TREADY),
        .outStream_TDATA  (outStream_TDATA),
        .outStream_TVALID (outStream_TVALID),
        .outStream_TREADY (outStream_TREADY),
        .outStream_TDEST  (outStream_TDEST),
        .tw_overflow      (tw_overflow),
        .tw_busy_entries  (tw_busy_entries)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [3:0] tid);
        int n = 0;
        inStream_TDATA  = d;
        inStream_TID    = tid;
        inStream_TVALID = 1'b1;
        while (!inStream_TREADY && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL beat_timeout: TREADY never rose for data %0h", d);
        end
        @(posedge clk);
        #1;
        inStream_TVALID = 1'b0;
    endtask

    // Sends both beats, then steps through LOOKUP and UPDATE
    task automatic send_msg(input logic is_wait, input logic [31:0] comp,
                            input logic [63:0] id, input logic [3:0] tid);
        send_beat({31'b0, is_wait, comp}, tid);
        send_beat(id, tid);
        step(2);
    endtask

    task automatic expect_wake(input string tag, input logic v, input logic [3:0] d);
        check({tag, "_tvalid"}, 64'(outStream_TVALID), 64'(v));
        if (v) check({tag, "_tdest"}, 64'(outStream_TDEST), 64'(d));
        step(1);
    endtask

    logic [3:0] bp_tids [5];

    initial begin
        bp_tids[0] = 4'd9;  bp_tids[1] = 4'd2;  bp_tids[2] = 4'd14;
        bp_tids[3] = 4'd7;  bp_tids[4] = 4'd11;
        rstn = 1'b0;
        inStream_TDATA = '0;
        inStream_TVALID = 1'b0;
        inStream_TID = '0;
        outStream_TREADY = 1'b1;
        step(3);

        // Reset values, and ready held low for the first cycle after release
        check("rst_tready", 64'(inStream_TREADY), 64'd0);
        check("rst_tvalid", 64'(outStream_TVALID), 64'd0);
        check("rst_overflow", 64'(tw_overflow), 64'd0);
        check("rst_busy", 64'(tw_busy_entries), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rel_tready_first", 64'(inStream_TREADY), 64'd0);
        step(1);
        check("rel_tready_then", 64'(inStream_TREADY), 64'd1);
        check("tdata_token", 64'(outStream_TDATA), 64'd1);

        // WAIT before children finish
        send_msg(1'b1, 32'd2, 64'hA, 4'd3);
        check("a_wait_busy", 64'(tw_busy_entries), 64'd1);
        expect_wake("a_wait", 1'b0, 4'd0);
        send_msg(1'b0, 32'd0, 64'hA, 4'd7);
        check("a_fin1_busy", 64'(tw_busy_entries), 64'd1);
        expect_wake("a_fin1", 1'b0, 4'd0);
        send_msg(1'b0, 32'd0, 64'hA, 4'd8);
        check("a_fin2_busy", 64'(tw_busy_entries), 64'd0);
        expect_wake("a_fin2", 1'b1, 4'd3);
        check("a_drained", 64'(outStream_TVALID), 64'd0);

        // Children finish before the WAIT arrives
        send_msg(1'b0, 32'd0, 64'hB, 4'd6);
        send_msg(1'b0, 32'd0, 64'hB, 4'd6);
        check("b_fin_busy", 64'(tw_busy_entries), 64'd1);
        send_msg(1'b1, 32'd2, 64'hB, 4'd5);
        check("b_wait_busy", 64'(tw_busy_entries), 64'd0);
        expect_wake("b_wait", 1'b1, 4'd5);

        // WAIT with no children wakes at once without allocating
        send_msg(1'b1, 32'd0, 64'hC, 4'd1);
        check("c_busy", 64'(tw_busy_entries), 64'd0);
        expect_wake("c_wait", 1'b1, 4'd1);

        // Fill the table, then overflow it
        for (int i = 0; i < 16; i++) send_msg(1'b1, 32'd1, 64'h100 + 64'(i), 4'(i));
        check("fill_busy", 64'(tw_busy_entries), 64'd16);
        check("fill_overflow", 64'(tw_overflow), 64'd0);
        send_msg(1'b1, 32'd1, 64'h200, 4'd2);
        check("ovf_flag", 64'(tw_overflow), 64'd1);
        check("ovf_busy", 64'(tw_busy_entries), 64'd16);
        expect_wake("ovf", 1'b0, 4'd0);
        send_msg(1'b0, 32'd0, 64'h105, 4'd0);
        check("ovf_fin5_busy", 64'(tw_busy_entries), 64'd15);
        expect_wake("ovf_fin5", 1'b1, 4'd5);
        for (int i = 0; i < 16; i++) begin
            if (i != 5) begin
                send_msg(1'b0, 32'd0, 64'h100 + 64'(i), 4'd0);
                expect_wake($sformatf("drain%0d", i), 1'b1, 4'(i));
            end
        end
        check("drain_busy", 64'(tw_busy_entries), 64'd0);
        check("ovf_sticky", 64'(tw_overflow), 64'd1);

        // Wakeup backpressure: five completions into a four-deep FIFO
        outStream_TREADY = 1'b0;
        for (int k = 0; k < 5; k++) send_msg(1'b1, 32'd0, 64'h300 + 64'(k), bp_tids[k]);
        step(3);
        check("bp_hold_tready", 64'(inStream_TREADY), 64'd0);
        check("bp_tvalid", 64'(outStream_TVALID), 64'd1);
        check("bp_tdest_stable", 64'(outStream_TDEST), 64'(bp_tids[0]));
        outStream_TREADY = 1'b1;
        for (int k = 0; k < 5; k++) expect_wake($sformatf("bp%0d", k), 1'b1, bp_tids[k]);
        check("bp_empty", 64'(outStream_TVALID), 64'd0);
        check("bp_resume_tready", 64'(inStream_TREADY), 64'd1);

        // Reset between header and id beats discards everything
        outStream_TREADY = 1'b0;
        send_msg(1'b1, 32'd0, 64'h40, 4'd3);
        send_msg(1'b1, 32'd1, 64'h41, 4'd2);
        check("pre_rst_busy", 64'(tw_busy_entries), 64'd1);
        check("pre_rst_tvalid", 64'(outStream_TVALID), 64'd1);
        send_beat({31'b0, 1'b1, 32'd1}, 4'd4);
        rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_tready", 64'(inStream_TREADY), 64'd0);
        check("mid_rst_tvalid", 64'(outStream_TVALID), 64'd0);
        check("mid_rst_overflow", 64'(tw_overflow), 64'd0);
        check("mid_rst_busy", 64'(tw_busy_entries), 64'd0);
        rstn = 1'b1;
        outStream_TREADY = 1'b1;
        send_msg(1'b1, 32'd0, 64'hE, 4'd6);
        check("post_rst_busy", 64'(tw_busy_entries), 64'd0);
        expect_wake("post_rst", 1'b1, 4'd6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
